// File: rtl/dtfag_idx_seq.sv
// dtfag_idx_seq: stage/group/in-group index sequencer feeding the R16 twiddle AGU.
// Define DTFAG_STAGE_GAP_EN to insert GAP_CYC idle cycles after each inner stage boundary.
module dtfag_idx_seq #(
  parameter int N_LOG2  = 16,
  parameter int R_LOG2  = 4,
  parameter int STAGES  = N_LOG2 / R_LOG2,
  parameter int BF_W    = N_LOG2 - R_LOG2,
  parameter int GAP_CYC = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      idx_ready,
  output logic                      idx_valid,
  output logic [$clog2(STAGES)-1:0] DTFAG_i,
  output logic [BF_W-1:0]           DTFAG_t,
  output logic [BF_W-1:0]           DTFAG_j,
  output logic                      stage_last,
  output logic                      frame_last,
  output logic                      busy,
  output logic                      done
);

  localparam int SI_W = $clog2(STAGES);
  localparam logic [BF_W-1:0] B_MAX = {BF_W{1'b1}};
  localparam logic [SI_W-1:0] S_MAX = SI_W'(STAGES - 1);

  if (GAP_CYC < 1) begin : g_bad_gap
    $error("GAP_CYC must be at least 1");
  end
  if (N_LOG2 % R_LOG2 != 0) begin : g_bad_radix
    $error("N_LOG2 must be a multiple of R_LOG2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef DTFAG_STAGE_GAP_EN
    GAP  = 2'd3,
`endif
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SI_W-1:0]   s_q, s_d;
  logic [BF_W-1:0]   b_q, b_d;
  logic              valid_q, valid_d;
  logic [SI_W-1:0]   i_q, i_d;
  logic [BF_W-1:0]   t_q, t_d;
  logic [BF_W-1:0]   j_q, j_d;
  logic              sl_q, sl_d;
  logic              fl_q, fl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer;
  int                sh;

`ifdef DTFAG_STAGE_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  logic [GAP_W-1:0]  gap_q, gap_d;
`endif

  assign xfer = valid_q && idx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      i_q     <= '0;
      t_q     <= '0;
      j_q     <= '0;
      sl_q    <= 1'b0;
      fl_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DTFAG_STAGE_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      i_q     <= i_d;
      t_q     <= t_d;
      j_q     <= j_d;
      sl_q    <= sl_d;
      fl_q    <= fl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DTFAG_STAGE_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
`ifdef DTFAG_STAGE_GAP_EN
    gap_d   = gap_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (b_q != B_MAX) begin
            b_d = b_q + 1'b1;
          end else if (s_q != S_MAX) begin
            b_d = '0;
            s_d = s_q + 1'b1;
`ifdef DTFAG_STAGE_GAP_EN
            state_d = GAP;
            gap_d   = '0;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
`ifdef DTFAG_STAGE_GAP_EN
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = RUN;
        else gap_d = gap_q + 1'b1;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next-state counters.
  always_comb begin
    sh      = R_LOG2 * (STAGES - 1 - int'(s_d));
    valid_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    i_d     = '0;
    t_d     = '0;
    j_d     = '0;
    sl_d    = 1'b0;
    fl_d    = 1'b0;
    if (valid_d) begin
      i_d  = s_d;
      t_d  = b_d >> sh;
      j_d  = b_d & ~(B_MAX << sh);
      sl_d = (b_d == B_MAX);
      fl_d = (b_d == B_MAX) && (s_d == S_MAX);
    end
  end

  assign idx_valid  = valid_q;
  assign DTFAG_i    = i_q;
  assign DTFAG_t    = t_q;
  assign DTFAG_j    = j_q;
  assign stage_last = sl_q;
  assign frame_last = fl_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dtfag_idx_seq.sv
// tb_dtfag_idx_seq: full-frame, throttled, restart and reset checks of dtfag_idx_seq
// against an arithmetic model of the stage/group/in-group decomposition.
module tb_dtfag_idx_seq;

  localparam int BF  = 4096;
  localparam int NXF = 16384;
`ifdef DTFAG_STAGE_GAP_EN
  localparam int GAPX = 8;
  localparam int NGAP = 3;
`else
  localparam int GAPX = 0;
  localparam int NGAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        idx_ready = 1'b0;
  logic        idx_valid;
  logic [1:0]  DTFAG_i;
  logic [11:0] DTFAG_t;
  logic [11:0] DTFAG_j;
  logic        stage_last;
  logic        frame_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dtfag_idx_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .idx_ready  (idx_ready),
    .idx_valid  (idx_valid),
    .DTFAG_i    (DTFAG_i),
    .DTFAG_t    (DTFAG_t),
    .DTFAG_j    (DTFAG_j),
    .stage_last (stage_last),
    .frame_last (frame_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int n;
    int i;
    int t;
    int j;
    bit sl;
    bit fl;
  } vec_t;

  vec_t        tbl[9];
  logic [28:0] cap[NXF];

  function automatic logic [28:0] cur_set();
    return {idx_valid, DTFAG_i, DTFAG_t, DTFAG_j, stage_last, frame_last};
  endfunction

  // Expected index set of the k-th transfer (0-based) from plain div/mod.
  function automatic logic [28:0] ref_set(input int k);
    int s, b, div;
    s = k / BF;
    b = k % BF;
    div = 1;
    for (int m = 0; m < 3 - s; m++) div = div * 16;
    return {1'b1, 2'(s), 12'(b / div), 12'(b % div),
            b == BF - 1, k == NXF - 1};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int pct, input bit pokes);
    int nx = 0, nd = 0, ng = 0, inv = 0, cyc = 0, since = 1000;
    bit pv = 0, pr = 0, fin = 0, after = 0;
    logic [28:0] prev = '0, cur;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_valid", idx_valid, 1);
    while (!fin) begin
      cur = cur_set();
      if (pv && !pr) check("hold", cur, prev);
      start = 1'b0;
      if (after) begin
        check("idle_busy", busy, 0);
        check("idle_valid", idx_valid, 0);
        check("done_count", nd, 1);
        check("gap_count", ng, NGAP);
        fin = 1;
      end else if (done) begin
        nd++;
        check("done_lat", since, 1);
        check("done_xfers", nx, NXF);
        check("done_valid", idx_valid, 0);
        check("done_busy", busy, 1);
        check("no_final_gap", inv, 0);
        after = 1;
        if (pokes) start = 1'b1;
      end else begin
        if (busy && !idx_valid) inv++;
        if (idx_valid && inv > 0) begin
          check("gap_len", inv, GAPX);
          check("gap_at_boundary", (nx > 0 && nx % BF == 0), 1);
          ng++;
          inv = 0;
        end
        idx_ready = ($urandom_range(99) < pct);
        if (idx_valid && idx_ready) begin
          if (nx < NXF) begin
            total++;
            if (cur !== ref_set(nx)) begin
              bad++;
              $display("FAIL xfer %0d: got 0x%0h expected 0x%0h",
                       nx, cur, ref_set(nx));
            end
            cap[nx] = cur;
          end
          nx++;
          since = 0;
          if (pokes && nx == 100) start = 1'b1;
        end
      end
      since++;
      pv = idx_valid;
      pr = idx_ready;
      prev = cur;
      cyc++;
      if (!fin && cyc > 40000) begin
        check("frame_timeout", cyc, 0);
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
  endtask

  initial begin
    int k, cyc;
    tbl[0] = '{0,             0, 0,     0,     0, 0};
    tbl[1] = '{4095,          0, 0,     4095,  1, 0};
    tbl[2] = '{4096,          1, 0,     0,     0, 0};
    tbl[3] = '{4097,          1, 0,     1,     0, 0};
    tbl[4] = '{4096 + 'h5A7,  1, 'h5,   'hA7,  0, 0};
    tbl[5] = '{8192 + 'h5A7,  2, 'h5A,  'h7,   0, 0};
    tbl[6] = '{12288 + 'h5A7, 3, 'h5A7, 0,     0, 0};
    tbl[7] = '{8191,          1, 15,    255,   1, 0};
    tbl[8] = '{16383,         3, 4095,  0,     1, 1};

    repeat (3) @(negedge clk);
    check("rst_outputs", {cur_set(), busy, done}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", {cur_set(), busy, done}, 0);

    run_frame(100, 1'b1);
    foreach (tbl[v]) begin
      check($sformatf("tbl_%0d", tbl[v].n), cap[tbl[v].n],
            {1'b1, 2'(tbl[v].i), 12'(tbl[v].t), 12'(tbl[v].j),
             tbl[v].sl, tbl[v].fl});
    end

    run_frame(50, 1'b0);

    k = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx_ready = 1'b1;
    while (k < 5000 && cyc < 20000) begin
      if (idx_valid && idx_ready) k++;
      if (k < 5000) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("abort_reach", k, 5000);
    check("abort_pre_busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("abort_async", {cur_set(), busy, done}, 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_quiet", {done, busy, idx_valid}, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_done", done, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_first", cur_set(), ref_set(0));
    @(negedge clk);
    check("restart_second", cur_set(), ref_set(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
